// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder (drives in_ready and the result)
// Signals:
//   in_valid/in_ready    operand handshake; a, b, cin qualify it
//   out_valid/out_ready  result handshake; sum, cout, ovf qualify it
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built from one full-adder cell and a
// carry flop, iterated LSB first over WIDTH clocks.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: operands a, b, cin in; sum, cout, ovf out,
//          with valid/ready handshakes on both sides; one op in flight.
// The result appears exactly WIDTH clocks after the operand accept edge and
// is held until the downstream accepts it.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             c_msb;
    logic             cout_q;
    logic             ovf_q;

    // The single full-adder cell.
    logic s_bit;
    logic c_next;

    always_comb begin
        s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Carry is reloaded from cin on every accept, so nothing
                    // leaks from the previous operation.
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
                    carry  <= c_next;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB,
                    // needed for the signed overflow flag.
                    if (cnt == CNT_PRE) begin
                        c_msb <= c_next;
                    end
                    if (cnt == CNT_LAST) begin
                        sum_q  <= {s_bit, sum_sh[WIDTH-1:1]};
                        cout_q <= c_next;
                        ovf_q  <= c_msb ^ c_next;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
